axi_sim_system: RTL and testbench
=================================

// Module: axi_sim_system
// PURPOSE
// - Self-checking AXI4-Lite simulation system: a scripted master FSM, a register-bank slave and a checker.
// - Driven only by CLK and RESET; it is the top of the AXI simulation build, and its status outputs may be left unconnected.
// - After reset it writes every slave register, reads each one back and compares the data.
// - It then runs one out-of-range write and one out-of-range read, each expecting SLVERR.
// PARAMETERS
// NUM_REGS     16            number of 32-bit slave registers (1..63), byte address 4*i
// ADDR_WIDTH   8             AXI address width
// SEED         32'hA5A5_0000 write pattern base; register i is written with SEED+i
// START_DELAY  4             idle cycles after reset release before the first transaction
// TIMEOUT      64            max cycles waited for any single handshake
// INJECT_ERR   0             1: slave flips bit 0 of read data for register 5 (fault injection)
// PORTS
// CLK        in   1  system clock, all logic on rising edge
// RESET      in   1  asynchronous, active-high reset
// DONE       out  1  sequence finished (sticky until reset)
// PASS       out  1  DONE && ERR_COUNT==0
// ERR_COUNT  out  8  mismatch/response/timeout errors, saturates at 255
// BEHAVIOUR
// - Reset (async assert, sync release): DONE=0, PASS=0, ERR_COUNT=0, all VALID/READY=0, registers=0, FSM=IDLE.
// - Master FSM: IDLE(START_DELAY cycles) -> WR_REQ -> WR_RESP -> (next i, or RD_REQ at i=NUM_REGS) -> RD_REQ -> RD_DATA
//   -> (next i, or OOR_WR) -> OOR_WR_RESP -> OOR_RD -> OOR_RD_DATA -> FINISH. FINISH is terminal.
// - Write handshake:
//   - Master raises AWVALID and WVALID together (WSTRB=4'hF) and drops each independently on its READY.
//   - Slave pulses AWREADY=WREADY for exactly 1 cycle when both VALIDs are high and no BVALID is pending; the register updates on that edge.
//   - BVALID rises the next cycle and holds until BREADY; master holds BREADY=1 in WR_RESP.
// - Read handshake:
//   - Slave pulses ARREADY for 1 cycle when ARVALID is high and no RVALID is pending.
//   - RVALID+RDATA+RRESP appear next cycle and hold until RREADY.
// - Responses:
//   - In range (addr < 4*NUM_REGS, bits[1:0] ignored): OKAY (2'b00).
//   - Out of range: SLVERR (2'b10); writes are discarded and reads return 32'hDEAD_BEEF.
// - Checker (ERR_COUNT +1, saturating) on any of:
//   - a non-OKAY response in the in-range phases;
//   - RDATA != SEED+i;
//   - a response other than SLVERR in the OOR phases;
//   - any handshake wait exceeding TIMEOUT cycles; the FSM then abandons that transaction and advances.
// - Sequence completes in < 8*(2*NUM_REGS+2)+START_DELAY cycles; DONE/PASS register on entry to FINISH.
// - Reset mid-sequence: everything returns to reset values; the sequence restarts from i=0 after release.
// - Arithmetic: SEED+i is a 32-bit add that wraps; OOR address is 4*NUM_REGS truncated to ADDR_WIDTH.
// TESTING
// 1. RESET=1 for 10 cycles, release; defaults -> DONE=1 within 300 cycles, PASS=1, ERR_COUNT=0, reg[3]=32'hA5A5_0003.
// 2. Hold RESET=1 for 500 cycles -> DONE=0, PASS=0, ERR_COUNT=0, no VALID ever asserted.
// 3. Assert RESET 30 cycles after release, release again -> reg bank cleared to 0; DONE=1, PASS=1 after full rerun.
// 4. INJECT_ERR=1 -> DONE=1, ERR_COUNT=1, PASS=0.
// 5. NUM_REGS=1, SEED=32'hFFFF_FFFF -> reg[0]=32'hFFFF_FFFF; OOR addr 8'h04 gets SLVERR with RDATA 32'hDEAD_BEEF; PASS=1.
// 6. Handshake assertions every cycle: VALID never drops before READY; each READY pulse lasts 1 cycle; one outstanding transaction.

Source files
------------

// File: rtl/axi_sim_system_if.sv
// AXI4-Lite bus bundle shared by the scripted master and the register-bank slave.
interface axi_sim_system_if #(
  parameter int unsigned ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [31:0]           rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport monitor (
    input awaddr, awvalid, awready, wdata, wstrb, wvalid, wready, bresp, bvalid, bready,
          araddr, arvalid, arready, rdata, rresp, rvalid, rready
  );
endinterface

// File: rtl/axi_sim_system.sv
// Self-checking AXI4-Lite system: scripted write/read-back master with built-in checker,
// and a register-bank slave. m_bus and s_bus are expected to be tied to the same bus.
module axi_sim_system #(
  parameter int unsigned NUM_REGS    = 16,
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter logic [31:0] SEED        = 32'hA5A5_0000,
  parameter int unsigned START_DELAY = 4,
  parameter int unsigned TIMEOUT     = 64,
  parameter bit          INJECT_ERR  = 1'b0
) (
  input  logic             CLK,
  input  logic             RESET,
  axi_sim_system_if.master m_bus,
  axi_sim_system_if.slave  s_bus,
  output logic             DONE,
  output logic             PASS,
  output logic [7:0]       ERR_COUNT
);

  localparam int unsigned IDX_W    = 7;
  localparam int unsigned CNT_W    = 16;
  localparam int unsigned RIDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int unsigned NREG_P2  = 1 << RIDX_W;
  localparam int unsigned REG_SPAN = NUM_REGS * 4;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_REGS - 1);
  localparam logic [ADDR_WIDTH-1:0] OOR_ADDR = ADDR_WIDTH'(REG_SPAN);

  typedef enum logic [3:0] {
    IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA,
    OOR_WR, OOR_WR_RESP, OOR_RD, OOR_RD_DATA, FINISH
  } state_t;

  function automatic logic [ADDR_WIDTH-1:0] reg_addr(input logic [IDX_W-1:0] i);
    return ADDR_WIDTH'({i, 2'b00});
  endfunction

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
  logic                  bready_q, bready_d, rready_q, rready_d;
  logic [7:0]            err_q, err_d;
  logic                  done_q, done_d, pass_q, pass_d;
  logic                  err_inc, wr_next, rd_next, oor_rd, fin;
  logic                  timeout_c, start_c;

  assign timeout_c = (32'(cnt_q) + 32'd1) >= TIMEOUT;
  assign start_c   = (32'(cnt_q) + 32'd1) >= START_DELAY;

  // Master state and registered outputs
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      bready_q  <= 1'b0;
      rready_q  <= 1'b0;
      err_q     <= '0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      bready_q  <= bready_d;
      rready_q  <= rready_d;
      err_q     <= err_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
    end
  end

  // Master next-state, handshake sequencing and checker
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    bready_d  = bready_q;
    rready_d  = rready_q;
    err_d     = err_q;
    done_d    = done_q;
    pass_d    = pass_q;
    err_inc   = 1'b0;
    wr_next   = 1'b0;
    rd_next   = 1'b0;
    oor_rd    = 1'b0;
    fin       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_c) begin
          state_d   = WR_REQ;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          addr_d    = reg_addr(idx_q);
          wdata_d   = SEED + 32'(idx_q);
          cnt_d     = '0;
        end
      end
      WR_REQ, OOR_WR: begin
        if (m_bus.awready) awvalid_d = 1'b0;
        if (m_bus.wready)  wvalid_d  = 1'b0;
        if ((!awvalid_q || m_bus.awready) && (!wvalid_q || m_bus.wready)) begin
          state_d  = (state_q == WR_REQ) ? WR_RESP : OOR_WR_RESP;
          bready_d = 1'b1;
          cnt_d    = '0;
        end else if (timeout_c) begin
          err_inc   = 1'b1;
          awvalid_d = 1'b0;
          wvalid_d  = 1'b0;
          wr_next   = (state_q == WR_REQ);
          oor_rd    = (state_q == OOR_WR);
        end
      end
      WR_RESP, OOR_WR_RESP: begin
        if (m_bus.bvalid || timeout_c) begin
          bready_d = 1'b0;
          wr_next  = (state_q == WR_RESP);
          oor_rd   = (state_q == OOR_WR_RESP);
          if (!m_bus.bvalid)
            err_inc = 1'b1;
          else if (state_q == WR_RESP)
            err_inc = (m_bus.bresp != RESP_OKAY);
          else
            err_inc = (m_bus.bresp != RESP_SLVERR);
        end
      end
      RD_REQ, OOR_RD: begin
        if (m_bus.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          cnt_d     = '0;
          state_d   = (state_q == RD_REQ) ? RD_DATA : OOR_RD_DATA;
        end else if (timeout_c) begin
          err_inc   = 1'b1;
          arvalid_d = 1'b0;
          rd_next   = (state_q == RD_REQ);
          fin       = (state_q == OOR_RD);
        end
      end
      RD_DATA, OOR_RD_DATA: begin
        if (m_bus.rvalid || timeout_c) begin
          rready_d = 1'b0;
          rd_next  = (state_q == RD_DATA);
          fin      = (state_q == OOR_RD_DATA);
          if (!m_bus.rvalid)
            err_inc = 1'b1;
          else if (state_q == RD_DATA)
            err_inc = (m_bus.rresp != RESP_OKAY) || (m_bus.rdata != SEED + 32'(idx_q));
          else
            err_inc = (m_bus.rresp != RESP_SLVERR);
        end
      end
      FINISH: begin
      end
      default: state_d = IDLE;
    endcase

    // Launch the next transaction of the script
    if (wr_next) begin
      cnt_d = '0;
      if (idx_q == LAST_IDX) begin
        idx_d     = '0;
        state_d   = RD_REQ;
        arvalid_d = 1'b1;
        addr_d    = reg_addr('0);
      end else begin
        idx_d     = idx_q + IDX_W'(1);
        state_d   = WR_REQ;
        awvalid_d = 1'b1;
        wvalid_d  = 1'b1;
        addr_d    = reg_addr(idx_d);
        wdata_d   = SEED + 32'(idx_d);
      end
    end
    if (rd_next) begin
      cnt_d = '0;
      if (idx_q == LAST_IDX) begin
        state_d   = OOR_WR;
        awvalid_d = 1'b1;
        wvalid_d  = 1'b1;
        addr_d    = OOR_ADDR;
        wdata_d   = SEED;
      end else begin
        idx_d     = idx_q + IDX_W'(1);
        state_d   = RD_REQ;
        arvalid_d = 1'b1;
        addr_d    = reg_addr(idx_d);
      end
    end
    if (oor_rd) begin
      cnt_d     = '0;
      state_d   = OOR_RD;
      arvalid_d = 1'b1;
      addr_d    = OOR_ADDR;
    end
    if (err_inc && (err_q != 8'hFF)) err_d = err_q + 8'd1;
    if (fin) begin
      state_d = FINISH;
      done_d  = 1'b1;
      pass_d  = (err_d == 8'd0);
    end
  end

  assign m_bus.awaddr  = addr_q;
  assign m_bus.araddr  = addr_q;
  assign m_bus.awvalid = awvalid_q;
  assign m_bus.wvalid  = wvalid_q;
  assign m_bus.wdata   = wdata_q;
  assign m_bus.wstrb   = 4'hF;
  assign m_bus.bready  = bready_q;
  assign m_bus.arvalid = arvalid_q;
  assign m_bus.rready  = rready_q;

  assign DONE      = done_q;
  assign PASS      = pass_q;
  assign ERR_COUNT = err_q;

  // Slave: register bank, one outstanding write and one outstanding read
  logic [31:0]       regs [NREG_P2];
  logic              wr_rdy_q, bvalid_q, rd_rdy_q, rvalid_q;
  logic [1:0]        bresp_q, rresp_q;
  logic [31:0]       rdata_q, rd_word_c;
  logic [RIDX_W-1:0] wr_ridx, rd_ridx;
  logic              wr_in_c, rd_in_c, inj_c;

  assign wr_ridx   = RIDX_W'(s_bus.awaddr >> 2);
  assign rd_ridx   = RIDX_W'(s_bus.araddr >> 2);
  assign wr_in_c   = 32'(s_bus.awaddr) < REG_SPAN;
  assign rd_in_c   = 32'(s_bus.araddr) < REG_SPAN;
  assign inj_c     = INJECT_ERR && (NUM_REGS > 5) && (32'(rd_ridx) == 32'd5);
  assign rd_word_c = regs[rd_ridx] ^ {31'd0, inj_c};

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_rdy_q <= 1'b0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
      for (int i = 0; i < NREG_P2; i++) regs[i] <= '0;
    end else begin
      if (bvalid_q && s_bus.bready) bvalid_q <= 1'b0;
      if (wr_rdy_q) begin
        wr_rdy_q <= 1'b0;
        if (s_bus.awvalid && s_bus.wvalid) begin
          bvalid_q <= 1'b1;
          bresp_q  <= wr_in_c ? RESP_OKAY : RESP_SLVERR;
          if (wr_in_c) begin
            for (int b = 0; b < 4; b++)
              if (s_bus.wstrb[b]) regs[wr_ridx][8*b +: 8] <= s_bus.wdata[8*b +: 8];
          end
        end
      end else if (s_bus.awvalid && s_bus.wvalid && !bvalid_q) begin
        wr_rdy_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rd_rdy_q <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else begin
      if (rvalid_q && s_bus.rready) rvalid_q <= 1'b0;
      if (rd_rdy_q) begin
        rd_rdy_q <= 1'b0;
        if (s_bus.arvalid) begin
          rvalid_q <= 1'b1;
          rdata_q  <= rd_in_c ? rd_word_c : 32'hDEAD_BEEF;
          rresp_q  <= rd_in_c ? RESP_OKAY : RESP_SLVERR;
        end
      end else if (s_bus.arvalid && !rvalid_q) begin
        rd_rdy_q <= 1'b1;
      end
    end
  end

  assign s_bus.awready = wr_rdy_q;
  assign s_bus.wready  = wr_rdy_q;
  assign s_bus.bvalid  = bvalid_q;
  assign s_bus.bresp   = bresp_q;
  assign s_bus.arready = rd_rdy_q;
  assign s_bus.rvalid  = rvalid_q;
  assign s_bus.rdata   = rdata_q;
  assign s_bus.rresp   = rresp_q;

endmodule

// File: tb/tb_axi_sim_system.sv
// Bench for axi_sim_system: default, fault-injected and single-register builds run side by side.
module tb_axi_sim_system;

  localparam logic [31:0] SEED_A = 32'hA5A5_0000;
  localparam int unsigned NREG_A = 16;
  localparam logic [31:0] SEED_N = 32'hFFFF_FFFF;

  logic       CLK;
  logic       RESET;
  logic       done_a, pass_a, done_i, pass_i, done_n, pass_n;
  logic [7:0] err_a, err_i, err_n;

  axi_sim_system_if #(.ADDR_WIDTH(8)) bus_a ();
  axi_sim_system_if #(.ADDR_WIDTH(8)) bus_i ();
  axi_sim_system_if #(.ADDR_WIDTH(8)) bus_n ();

  axi_sim_system #(.NUM_REGS(NREG_A), .SEED(SEED_A)) dut_a (
    .CLK(CLK), .RESET(RESET), .m_bus(bus_a), .s_bus(bus_a),
    .DONE(done_a), .PASS(pass_a), .ERR_COUNT(err_a)
  );

  axi_sim_system #(.NUM_REGS(NREG_A), .SEED(SEED_A), .INJECT_ERR(1'b1)) dut_i (
    .CLK(CLK), .RESET(RESET), .m_bus(bus_i), .s_bus(bus_i),
    .DONE(done_i), .PASS(pass_i), .ERR_COUNT(err_i)
  );

  axi_sim_system #(.NUM_REGS(1), .SEED(SEED_N)) dut_n (
    .CLK(CLK), .RESET(RESET), .m_bus(bus_n), .s_bus(bus_n),
    .DONE(done_n), .PASS(pass_n), .ERR_COUNT(err_n)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  // Reference behaviour of the default slave for a given byte address
  function automatic exp_t model_access(input logic [7:0] addr);
    exp_t e;
    if (32'(addr) < 4 * NREG_A) begin
      e.data = SEED_A + 32'(addr >> 2);
      e.resp = 2'b00;
    end else begin
      e.data = 32'hDEAD_BEEF;
      e.resp = 2'b10;
    end
    return e;
  endfunction

  exp_t       rd_q[$];
  logic [1:0] b_q[$];
  exp_t       e_w, e_r;
  logic [1:0] e_b;
  int         n_wr, n_rd;
  logic       p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_bv, p_bb, p_rv, p_rr;
  logic       proto_bad;
  bit         valid_in_reset = 1'b0;
  logic [7:0] n_araddr;
  logic [31:0] n_rdata;
  logic [1:0] n_rresp, n_bresp;

  // Scoreboard and handshake protocol checks on the default build
  always @(negedge CLK) begin
    if (RESET) begin
      if (bus_a.awvalid || bus_a.wvalid || bus_a.arvalid || bus_a.bvalid || bus_a.rvalid ||
          bus_i.awvalid || bus_i.wvalid || bus_i.arvalid || bus_i.bvalid || bus_i.rvalid ||
          bus_n.awvalid || bus_n.wvalid || bus_n.arvalid || bus_n.bvalid || bus_n.rvalid)
        valid_in_reset = 1'b1;
      rd_q.delete();
      b_q.delete();
      n_wr = 0;
      n_rd = 0;
      {p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_bv, p_bb, p_rv, p_rr} = '0;
    end else begin
      proto_bad = (p_awv && !p_awr && !bus_a.awvalid) || (p_wv && !p_wr && !bus_a.wvalid) ||
                  (p_arv && !p_arr && !bus_a.arvalid) || (p_bv && !p_bb && !bus_a.bvalid) ||
                  (p_rv && !p_rr && !bus_a.rvalid) || (p_awr && bus_a.awready) ||
                  (p_wr && bus_a.wready) || (p_arr && bus_a.arready) ||
                  ((bus_a.awvalid || bus_a.bvalid) && (bus_a.arvalid || bus_a.rvalid));
      check("protocol", 32'(proto_bad), 32'd0);
      if (bus_a.awvalid && bus_a.awready) begin
        e_w = model_access(bus_a.awaddr);
        if (e_w.resp == 2'b00) check("wdata", bus_a.wdata, e_w.data);
        b_q.push_back(e_w.resp);
        n_wr++;
      end
      if (bus_a.bvalid && bus_a.bready) begin
        check("b_pending", 32'(b_q.size() != 0), 32'd1);
        if (b_q.size() != 0) begin
          e_b = b_q.pop_front();
          check("bresp", 32'(bus_a.bresp), 32'(e_b));
        end
      end
      if (bus_a.arvalid && bus_a.arready) rd_q.push_back(model_access(bus_a.araddr));
      if (bus_a.rvalid && bus_a.rready) begin
        check("r_pending", 32'(rd_q.size() != 0), 32'd1);
        if (rd_q.size() != 0) begin
          e_r = rd_q.pop_front();
          check("rdata", bus_a.rdata, e_r.data);
          check("rresp", 32'(bus_a.rresp), 32'(e_r.resp));
          n_rd++;
        end
      end
      {p_awv, p_awr, p_wv, p_wr, p_arv, p_arr} =
        {bus_a.awvalid, bus_a.awready, bus_a.wvalid, bus_a.wready, bus_a.arvalid, bus_a.arready};
      {p_bv, p_bb, p_rv, p_rr} = {bus_a.bvalid, bus_a.bready, bus_a.rvalid, bus_a.rready};
    end
  end

  // Last observed beats of the single-register build
  always @(negedge CLK) begin
    if (RESET) begin
      n_araddr = '0;
      n_rdata  = '0;
      n_rresp  = '0;
      n_bresp  = '0;
    end else begin
      if (bus_n.arvalid && bus_n.arready) n_araddr = bus_n.araddr;
      if (bus_n.rvalid && bus_n.rready) begin
        n_rdata = bus_n.rdata;
        n_rresp = bus_n.rresp;
      end
      if (bus_n.bvalid && bus_n.bready) n_bresp = bus_n.bresp;
    end
  end

  logic all_done;

  initial begin
    RESET = 1'b1;

    // Long reset: nothing moves
    repeat (500) @(posedge CLK);
    #1;
    check("reset_no_valid", 32'(valid_in_reset), 32'd0);
    check("reset_done_a", 32'(done_a), 32'd0);
    check("reset_pass_a", 32'(pass_a), 32'd0);
    check("reset_err_a", 32'(err_a), 32'd0);
    check("reset_done_n", 32'(done_n), 32'd0);
    check("reset_err_i", 32'(err_i), 32'd0);
    check("reset_reg3", dut_a.regs[3], 32'd0);

    // Release, then interrupt the sequence part-way through
    RESET = 1'b0;
    repeat (30) @(posedge CLK);
    #1;
    check("midseq_reg0", dut_a.regs[0], SEED_A);
    check("midseq_done", 32'(done_a), 32'd0);
    RESET = 1'b1;
    #1;
    check("async_clear_reg0", dut_a.regs[0], 32'd0);
    repeat (10) @(posedge CLK);
    #1;
    check("rereset_reg1", dut_a.regs[1], 32'd0);
    check("rereset_err", 32'(err_a), 32'd0);
    check("rereset_done", 32'(done_a), 32'd0);
    RESET = 1'b0;

    all_done = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(posedge CLK);
      #1;
      all_done = done_a && done_i && done_n;
      if (all_done) break;
    end
    check("done_within_300", 32'(all_done), 32'd1);

    repeat (20) @(posedge CLK);
    #1;
    check("a_done_sticky", 32'(done_a), 32'd1);
    check("a_pass", 32'(pass_a), 32'd1);
    check("a_err", 32'(err_a), 32'd0);
    check("a_reg3", dut_a.regs[3], 32'hA5A5_0003);
    check("a_reg15", dut_a.regs[15], 32'hA5A5_000F);
    check("a_writes", 32'(n_wr), 32'(NREG_A + 1));
    check("a_reads", 32'(n_rd), 32'(NREG_A + 1));
    check("a_rq_empty", 32'(rd_q.size()), 32'd0);
    check("a_bq_empty", 32'(b_q.size()), 32'd0);
    check("i_done", 32'(done_i), 32'd1);
    check("i_err", 32'(err_i), 32'd1);
    check("i_pass", 32'(pass_i), 32'd0);
    check("n_reg0", dut_n.regs[0], 32'hFFFF_FFFF);
    check("n_oor_addr", 32'(n_araddr), 32'h04);
    check("n_oor_rdata", n_rdata, 32'hDEAD_BEEF);
    check("n_oor_rresp", 32'(n_rresp), 32'd2);
    check("n_oor_bresp", 32'(n_bresp), 32'd2);
    check("n_pass", 32'(pass_n), 32'd1);
    check("n_err", 32'(err_n), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
